tail_light_sequencer: RTL and testbench

Consumes the 2-bit controller state (IDLE / TURN / HAZARD, encoded by the `params.vh` constants) and drives the six tail lights, three per side. It is the output end of the light-controller state interface. A prescaler divides `clk` into animation steps. A 2-bit phase counter then produces either the sequential turn sweep on one side or the all-on/all-off hazard flash on both sides.

---
 rtl/tail_light_sequencer.sv | 83 ++++++++
 tb/tb_tail_light_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: turns the controller mode (IDLE / TURN / HAZARD) into
// the six tail-light outputs, paced by a prescaled animation step.
module tail_light_sequencer #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] state,
    input  logic       left,
    output logic [2:0] lights_l,
    output logic [2:0] lights_r
);

    // Controller state encoding shared with the light-controller FSM.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TURN   = 2'd1;
    localparam logic [1:0] HAZARD = 2'd2;

    localparam int             PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [1:0]       state_q;
    logic             left_q;
    logic [PRE_W-1:0] pre;
    logic [1:0]       phase;

    logic restart;
    logic active;
    logic [2:0] sweep;

    // A direction change only matters while a sweep is showing.
    assign restart = (state != state_q) || ((state == TURN) && (left != left_q));
    assign active  = (state_q == TURN) || (state_q == HAZARD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset branch clears all of them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            left_q  <= 1'b0;
            pre     <= '0;
            phase   <= 2'd0;
        end else begin
            state_q <= state;
            left_q  <= left;
            if (restart || !active) begin
                pre   <= '0;
                phase <= 2'd0;
            end else if (pre == PRE_MAX) begin
                pre   <= '0;
                phase <= phase + 2'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Outputs depend only on registered state, so inputs never reach them combinationally.
    always_comb begin
        lights_l = 3'b000;
        lights_r = 3'b000;
        case (phase)
            2'd0:    sweep = 3'b000;
            2'd1:    sweep = 3'b001;
            2'd2:    sweep = 3'b011;
            default: sweep = 3'b111;
        endcase
        case (state_q)
            TURN: begin
                if (left_q) lights_l = sweep;
                else        lights_r = sweep;
            end
            HAZARD: begin
                if (!phase[0]) begin
                    lights_l = 3'b111;
                    lights_r = 3'b111;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer: stimulus queues the expected
// lights for each edge, a monitor pops and compares after that edge.
module tb_tail_light_sequencer;

    localparam int TICK_DIV = 4;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TURN   = 2'd1;
    localparam logic [1:0] HAZARD = 2'd2;
    localparam logic [1:0] BADCODE = 2'd3;
    localparam logic [2:0] SWEEP [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

    typedef struct {
        logic [2:0] l;
        logic [2:0] r;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] state;
    logic       left;
    logic [2:0] lights_l;
    logic [2:0] lights_r;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    event sample_ev;

    tail_light_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .state    (state),
        .left     (left),
        .lights_l (lights_l),
        .lights_r (lights_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares one queued expectation after each edge or forced sample.
    initial begin
        forever begin
            @(posedge clk or sample_ev);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (lights_l !== e.l || lights_r !== e.r) begin
                    n_err++;
                    $display("FAIL %s: got l=%b r=%b, expected l=%b r=%b at %0t",
                             e.name, lights_l, lights_r, e.l, e.r, $time);
                end
            end
        end
    end

    // Drive inputs mid-cycle and queue what the outputs must be after the next edge.
    task automatic step(input logic rn, input logic [1:0] st, input logic lf,
                        input logic [2:0] el, input logic [2:0] er, input string nm);
        exp_t e;
        @(posedge clk);
        #3;
        reset_n = rn;
        state   = st;
        left    = lf;
        e.l = el;
        e.r = er;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        state   = HAZARD;
        left    = 1'b0;

        // 1. Reset holds outputs dark even with HAZARD requested.
        for (int i = 0; i < 3; i++) step(1'b0, HAZARD, 1'b0, 3'b000, 3'b000, "reset_hold");
        step(1'b1, HAZARD, 1'b0, 3'b111, 3'b111, "reset_release");
        step(1'b1, IDLE, 1'b0, 3'b000, 3'b000, "to_idle");

        // 2. Left sweep, each value for exactly TICK_DIV edges, then wrap.
        for (int i = 0; i < 20; i++)
            step(1'b1, TURN, 1'b1, SWEEP[(i / TICK_DIV) % 4], 3'b000, "left_sweep");
        step(1'b1, IDLE, 1'b0, 3'b000, 3'b000, "to_idle");

        // 3. Hazard flash starts on, toggles every TICK_DIV edges.
        for (int i = 0; i < 16; i++)
            step(1'b1, HAZARD, 1'b0, ((i / TICK_DIV) % 2 == 0) ? 3'b111 : 3'b000,
                 ((i / TICK_DIV) % 2 == 0) ? 3'b111 : 3'b000, "hazard_flash");
        step(1'b1, IDLE, 1'b0, 3'b000, 3'b000, "to_idle");

        // 4. Direction change mid-sweep restarts on the other side.
        for (int i = 0; i < 9; i++)
            step(1'b1, TURN, 1'b1, SWEEP[(i / TICK_DIV) % 4], 3'b000, "dir_pre");
        for (int k = 0; k < 8; k++)
            step(1'b1, TURN, 1'b0, 3'b000, SWEEP[(k / TICK_DIV) % 4], "dir_change");
        step(1'b1, IDLE, 1'b0, 3'b000, 3'b000, "to_idle");

        // 5. Invalid code stays dark; hazard ignores left toggling.
        for (int i = 0; i < 10; i++) step(1'b1, BADCODE, 1'b1, 3'b000, 3'b000, "invalid_code");
        for (int i = 0; i < 16; i++)
            step(1'b1, HAZARD, i[0], ((i / TICK_DIV) % 2 == 0) ? 3'b111 : 3'b000,
                 ((i / TICK_DIV) % 2 == 0) ? 3'b111 : 3'b000, "hazard_left_toggle");

        // TURN -> HAZARD -> TURN re-enters at phase 0.
        for (int i = 0; i < 6; i++)
            step(1'b1, TURN, 1'b0, 3'b000, SWEEP[(i / TICK_DIV) % 4], "turn_a");
        step(1'b1, HAZARD, 1'b0, 3'b111, 3'b111, "turn_to_hazard");
        step(1'b1, TURN, 1'b0, 3'b000, 3'b000, "hazard_to_turn");
        step(1'b1, IDLE, 1'b0, 3'b000, 3'b000, "to_idle");

        // 6. Async reset at phase 3 blanks before the next edge; sweep restarts.
        for (int i = 0; i < 13; i++)
            step(1'b1, TURN, 1'b0, 3'b000, SWEEP[(i / TICK_DIV) % 4], "turn_to_p3");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        begin
            exp_t e;
            e.l = 3'b000;
            e.r = 3'b000;
            e.name = "async_reset";
            exp_q.push_back(e);
        end
        ->sample_ev;
        for (int k = 0; k < 6; k++)
            step(1'b1, TURN, 1'b0, 3'b000, SWEEP[(k / TICK_DIV) % 4], "after_reset");

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
